// File: rtl/pcm_bit_packetizer.sv
// pcm_bit_packetizer
//
// Buffers PCM samples in a FIFO and sends them as fixed-size packets of
// serial bits to the bitwise RTP sender. Each packet is one prepare_out
// strobe, carrying the index of its first sample, followed by
// SAMPLES_PER_PACKET*SAMPLE_WIDTH contiguous payload bits. Each sample is
// sent MSB first.
//
// Ports
//   clk_100mhz        in   system clock
//   rst               in   asynchronous, active-high reset
//   sample_in         in   PCM sample
//   sample_valid_in   in   one-cycle strobe qualifying sample_in
//   eth_busy          in   MAC transmitter busy (sampled only in IDLE)
//   ready_in          in   RTP stage ready (sampled only in WAIT_READY)
//   prepare_out       out  one-cycle header request to the RTP stage
//   packet_nbits      out  constant payload size in bits
//   packet_timestamp  out  index of the packet's first sample
//   stream_out        out  payload bit
//   stream_out_valid  out  qualifies stream_out
//   overflow_out      out  sticky: a sample was dropped on a full FIFO
//   fill_level        out  FIFO occupancy (one bit wider than the pointers)
module pcm_bit_packetizer #(
  parameter int SAMPLE_WIDTH       = 16,
  parameter int SAMPLES_PER_PACKET = 32,
  parameter int FIFO_DEPTH         = 128,
  parameter int READY_TIMEOUT      = 1024
) (
  input  logic                          clk_100mhz,
  input  logic                          rst,
  input  logic [SAMPLE_WIDTH-1:0]       sample_in,
  input  logic                          sample_valid_in,
  input  logic                          eth_busy,
  input  logic                          ready_in,
  output logic                          prepare_out,
  output logic [15:0]                   packet_nbits,
  output logic [31:0]                   packet_timestamp,
  output logic                          stream_out,
  output logic                          stream_out_valid,
  output logic                          overflow_out,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;
  localparam int SW = (SAMPLES_PER_PACKET > 1) ? $clog2(SAMPLES_PER_PACKET) : 1;
  localparam int TW = $clog2(READY_TIMEOUT + 1);

  localparam logic [CW-1:0] FULL_LVL = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] PKT_LVL  = CW'(SAMPLES_PER_PACKET);
  localparam logic [BW-1:0] LAST_BIT = BW'(SAMPLE_WIDTH - 1);
  localparam logic [SW-1:0] LAST_SMP = SW'(SAMPLES_PER_PACKET - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(READY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREPARE,
    S_WAIT_READY,
    S_STREAM
  } state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------
  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    push, pop;
  logic [SAMPLE_WIDTH-1:0] head;

  // Fullness uses the start-of-cycle occupancy, so a pop in the same
  // cycle does not make room for an incoming sample.
  assign push = sample_valid_in && (count < FULL_LVL);
  assign head = mem[rd_ptr];

  always_ff @(posedge clk_100mhz) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_out <= 1'b0;
    end else begin
      // Pointers are AW bits wide, so they wrap modulo FIFO_DEPTH.
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (sample_valid_in && (count == FULL_LVL)) overflow_out <= 1'b1;
    end
  end

  assign fill_level = count;

  // ---------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------
  logic [SAMPLE_WIDTH-1:0] shreg;
  logic [BW-1:0]           bit_idx;
  logic [SW-1:0]           smp_idx;
  logic [TW-1:0]           wait_cnt;
  logic [31:0]             sample_count;
  logic                    latch_ts;
  logic                    load;

  always_comb begin
    state_nxt = state;
    latch_ts  = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        // Only a full packet's worth of samples starts a packet, so the
        // pops during STREAM can never underflow.
        if ((count >= PKT_LVL) && !eth_busy) begin
          latch_ts  = 1'b1;
          state_nxt = S_PREPARE;
        end
      end
      S_PREPARE: state_nxt = S_WAIT_READY;
      S_WAIT_READY: begin
        // ready_in wins over a timeout that expires in the same cycle.
        if (ready_in) begin
          pop       = 1'b1;
          load      = 1'b1;
          state_nxt = S_STREAM;
        end else if (wait_cnt == TMO_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      S_STREAM: begin
        // The next sample is loaded on the last bit of the current one,
        // which keeps the bit stream gapless across sample boundaries.
        if (bit_idx == LAST_BIT) begin
          if (smp_idx != LAST_SMP) begin
            pop  = 1'b1;
            load = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      shreg            <= '0;
      bit_idx          <= '0;
      smp_idx          <= '0;
      wait_cnt         <= '0;
      sample_count     <= '0;
      packet_timestamp <= '0;
    end else begin
      state <= state_nxt;

      // A timed-out prepare re-latches here; no pops happened, so the
      // retry carries the same timestamp.
      if (latch_ts) packet_timestamp <= sample_count;
      if (pop)      sample_count     <= sample_count + 32'd1;

      if (state == S_PREPARE)         wait_cnt <= '0;
      else if (state == S_WAIT_READY) wait_cnt <= wait_cnt + TW'(1);

      if (load) begin
        shreg   <= head;
        bit_idx <= '0;
        smp_idx <= (state == S_WAIT_READY) ? '0 : smp_idx + SW'(1);
      end else if (state == S_STREAM) begin
        shreg   <= shreg << 1;
        bit_idx <= bit_idx + BW'(1);
      end
    end
  end

  // Outputs decode straight from registered state, so an asynchronous
  // reset drops stream_out_valid immediately.
  assign prepare_out      = (state == S_PREPARE);
  assign stream_out_valid = (state == S_STREAM);
  assign stream_out       = stream_out_valid & shreg[SAMPLE_WIDTH-1];
  assign packet_nbits     = 16'(SAMPLES_PER_PACKET * SAMPLE_WIDTH);

endmodule

// File: tb/tb_pcm_bit_packetizer.sv
module tb_pcm_bit_packetizer;
  localparam int W     = 16;
  localparam int SPP   = 4;
  localparam int DEPTH = 16;
  localparam int TMO   = 20;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_in = '0;
  logic        sample_valid_in = 1'b0;
  logic        eth_busy = 1'b0;
  logic        ready_in = 1'b0;
  logic        prepare_out;
  logic [15:0] packet_nbits;
  logic [31:0] packet_timestamp;
  logic        stream_out;
  logic        stream_out_valid;
  logic        overflow_out;
  logic [4:0]  fill_level;

  int n_chk = 0;
  int n_pass = 0;

  pcm_bit_packetizer #(
    .SAMPLE_WIDTH(W), .SAMPLES_PER_PACKET(SPP),
    .FIFO_DEPTH(DEPTH), .READY_TIMEOUT(TMO)
  ) dut (
    .clk_100mhz(clk_100mhz), .rst(rst),
    .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .eth_busy(eth_busy), .ready_in(ready_in),
    .prepare_out(prepare_out), .packet_nbits(packet_nbits),
    .packet_timestamp(packet_timestamp), .stream_out(stream_out),
    .stream_out_valid(stream_out_valid), .overflow_out(overflow_out),
    .fill_level(fill_level)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 500000 time units");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    rst = 1'b1;
    sample_valid_in = 1'b0;
    eth_busy = 1'b0;
    ready_in = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    rst = 1'b0;
    @(negedge clk_100mhz);
  endtask

  task automatic push_one(input logic [15:0] v);
    @(negedge clk_100mhz);
    sample_valid_in = 1'b1;
    sample_in = v;
  endtask

  task automatic end_push();
    @(negedge clk_100mhz);
    sample_valid_in = 1'b0;
  endtask

  // Waits for prepare_out (counting from the current negedge), answers
  // with ready_in after rdy_dly cycles and captures the full payload.
  task automatic recv_packet(input string nm, input logic [31:0] exp_ts,
                             input logic [63:0] exp_bits, input int rdy_dly,
                             input int max_wait, input bit keep_ready,
                             output int waited);
    logic [63:0] got;
    bit gap_err;
    bit prep_err;
    int nd;
    waited = 0;
    got = '0;
    gap_err = 1'b0;
    prep_err = 1'b0;
    while (!prepare_out && waited < max_wait) begin
      @(negedge clk_100mhz);
      waited++;
    end
    n_chk++;
    if (prepare_out !== 1'b1) begin
      $display("FAIL %s_prepare: prepare_out not seen within %0d cycles", nm, max_wait);
      return;
    end
    n_pass++;
    n_chk++;
    if (packet_timestamp !== exp_ts)
      $display("FAIL %s_ts: got %0d expected %0d", nm, packet_timestamp, exp_ts);
    else n_pass++;
    n_chk++;
    if (packet_nbits !== 16'd64)
      $display("FAIL %s_nbits: got %0d expected 64", nm, packet_nbits);
    else n_pass++;
    nd = (rdy_dly > 1) ? rdy_dly : 1;
    for (int i = 0; i < nd; i++) begin
      @(negedge clk_100mhz);
      if (prepare_out !== 1'b0 || stream_out_valid !== 1'b0) prep_err = 1'b1;
    end
    n_chk++;
    if (prep_err)
      $display("FAIL %s_prepare_width: prepare_out/valid high after prepare got 1 expected 0", nm);
    else n_pass++;
    ready_in = 1'b1;
    @(negedge clk_100mhz);
    if (!keep_ready) ready_in = 1'b0;
    n_chk++;
    if (stream_out_valid !== 1'b1)
      $display("FAIL %s_stream_latency: valid got %b expected 1", nm, stream_out_valid);
    else n_pass++;
    for (int i = 0; i < 64; i++) begin
      if (stream_out_valid !== 1'b1) gap_err = 1'b1;
      got = {got[62:0], stream_out};
      if (i != 63) @(negedge clk_100mhz);
    end
    n_chk++;
    if (gap_err)
      $display("FAIL %s_contiguous: valid dropped inside 64-bit payload expected contiguous", nm);
    else n_pass++;
    n_chk++;
    if (got !== exp_bits)
      $display("FAIL %s_payload: got %h expected %h", nm, got, exp_bits);
    else n_pass++;
    @(negedge clk_100mhz);
    n_chk++;
    if (stream_out_valid !== 1'b0)
      $display("FAIL %s_duration: valid after 64 bits got %b expected 0", nm, stream_out_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (fill_level !== 5'd0) $display("FAIL reset_fill: got %0d expected 0", fill_level);
    else n_pass++;
    n_chk++;
    if (overflow_out !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow_out);
    else n_pass++;
    n_chk++;
    if ({prepare_out, stream_out, stream_out_valid} !== 3'b000)
      $display("FAIL reset_ctl: got %b expected 000", {prepare_out, stream_out, stream_out_valid});
    else n_pass++;
    n_chk++;
    if (packet_timestamp !== 32'd0) $display("FAIL reset_ts: got %0d expected 0", packet_timestamp);
    else n_pass++;
    n_chk++;
    if (packet_nbits !== 16'd64) $display("FAIL reset_nbits: got %0d expected 64", packet_nbits);
    else n_pass++;
  endtask

  task automatic test_single_packet();
    int w;
    push_one(16'h8001); push_one(16'h0002); push_one(16'h0003); push_one(16'h0004);
    end_push();
    n_chk++;
    if (fill_level !== 5'd4) $display("FAIL single_fill: got %0d expected 4", fill_level);
    else n_pass++;
    recv_packet("single", 32'd0, 64'h8001_0002_0003_0004, 2, 10, 1'b0, w);
    n_chk++;
    if (w !== 1) $display("FAIL single_prepare_latency: got %0d expected 1", w);
    else n_pass++;
  endtask

  task automatic test_busy_holdoff();
    int w;
    bit bad;
    bad = 1'b0;
    eth_busy = 1'b1;
    push_one(16'hA5A5); push_one(16'h5A5A); push_one(16'hFFFF); push_one(16'h0000);
    end_push();
    repeat (50) begin
      @(negedge clk_100mhz);
      if (prepare_out !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad) $display("FAIL busy_hold: prepare_out got 1 while busy expected 0");
    else n_pass++;
    n_chk++;
    if (fill_level !== 5'd4) $display("FAIL busy_fill: got %0d expected 4", fill_level);
    else n_pass++;
    eth_busy = 1'b0;
    @(negedge clk_100mhz);
    n_chk++;
    if (prepare_out !== 1'b1) $display("FAIL busy_release: prepare_out got %b expected 1", prepare_out);
    else n_pass++;
    recv_packet("busy", 32'd4, 64'hA5A5_5A5A_FFFF_0000, 2, 0, 1'b0, w);
  endtask

  task automatic test_timeout_retry();
    int w;
    int n;
    bit bad;
    bad = 1'b0;
    ready_in = 1'b0;
    push_one(16'h1234); push_one(16'h5678); push_one(16'h9ABC); push_one(16'hDEF0);
    end_push();
    n = 0;
    while (!prepare_out && n < 10) begin
      @(negedge clk_100mhz);
      n++;
    end
    n_chk++;
    if (prepare_out !== 1'b1 || packet_timestamp !== 32'd8)
      $display("FAIL timeout_first: prepare %b ts %0d expected 1 and 8", prepare_out, packet_timestamp);
    else n_pass++;
    n = 0;
    do begin
      @(negedge clk_100mhz);
      n++;
      if (stream_out_valid !== 1'b0) bad = 1'b1;
    end while (!prepare_out && n < TMO + 10);
    n_chk++;
    if (n < TMO + 1 || n > TMO + 3)
      $display("FAIL timeout_retry_gap: got %0d cycles expected %0d..%0d", n, TMO + 1, TMO + 3);
    else n_pass++;
    n_chk++;
    if (bad) $display("FAIL timeout_no_stream: valid got 1 during wait expected 0");
    else n_pass++;
    n_chk++;
    if (fill_level !== 5'd4) $display("FAIL timeout_fill: got %0d expected 4", fill_level);
    else n_pass++;
    recv_packet("retry", 32'd8, 64'h1234_5678_9ABC_DEF0, 2, 0, 1'b0, w);
  endtask

  task automatic test_overflow();
    int w;
    logic [63:0] e;
    logic [15:0] b;
    bit bad;
    eth_busy = 1'b1;
    ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_one(16'h0100 + 16'(i));
    end_push();
    n_chk++;
    if (fill_level !== 5'd16 || overflow_out !== 1'b0)
      $display("FAIL overflow_at_full: fill %0d ovf %b expected 16 and 0", fill_level, overflow_out);
    else n_pass++;
    for (int i = 0; i < 3; i++) push_one(16'hEE00 + 16'(i));
    end_push();
    n_chk++;
    if (fill_level !== 5'd16 || overflow_out !== 1'b1)
      $display("FAIL overflow_drop: fill %0d ovf %b expected 16 and 1", fill_level, overflow_out);
    else n_pass++;
    eth_busy = 1'b0;
    for (int p = 0; p < 4; p++) begin
      b = 16'h0100 + 16'(4 * p);
      e = {b, b + 16'd1, b + 16'd2, b + 16'd3};
      recv_packet("ovf_drain", 32'd12 + 32'(4 * p), e, 1, 10, 1'b0, w);
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk_100mhz);
      if (prepare_out !== 1'b0) bad = 1'b1;
    end
    n_chk++;
    if (bad || fill_level !== 5'd0)
      $display("FAIL overflow_dropped_absent: fill %0d extra prepare %b expected 0 and 0", fill_level, bad);
    else n_pass++;
  endtask

  task automatic test_reset_mid_stream();
    int w;
    int n;
    eth_busy = 1'b1;
    for (int i = 0; i < 6; i++) push_one(16'h7700 + 16'(i));
    end_push();
    eth_busy = 1'b0;
    n = 0;
    while (!prepare_out && n < 10) begin
      @(negedge clk_100mhz);
      n++;
    end
    @(negedge clk_100mhz);
    ready_in = 1'b1;
    n = 0;
    while (!stream_out_valid && n < 5) begin
      @(negedge clk_100mhz);
      n++;
    end
    ready_in = 1'b0;
    repeat (20) @(negedge clk_100mhz);
    n_chk++;
    if (stream_out_valid !== 1'b1) $display("FAIL midrst_streaming: valid got %b expected 1", stream_out_valid);
    else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (stream_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", stream_out_valid);
    else n_pass++;
    n_chk++;
    if (fill_level !== 5'd0 || overflow_out !== 1'b0)
      $display("FAIL midrst_state: fill %0d ovf %b expected 0 and 0", fill_level, overflow_out);
    else n_pass++;
    @(negedge clk_100mhz);
    @(negedge clk_100mhz);
    rst = 1'b0;
    push_one(16'h4321); push_one(16'h8765); push_one(16'h0F0F); push_one(16'hF0F0);
    end_push();
    recv_packet("midrst_next", 32'd0, 64'h4321_8765_0F0F_F0F0, 2, 10, 1'b0, w);
  endtask

  task automatic test_back_to_back();
    int w;
    logic [63:0] e;
    logic [15:0] b;
    apply_reset();
    eth_busy = 1'b1;
    for (int i = 0; i < 3 * SPP; i++) push_one(16'h1000 + 16'(i * 17));
    end_push();
    n_chk++;
    if (fill_level !== 5'd12) $display("FAIL b2b_fill: got %0d expected 12", fill_level);
    else n_pass++;
    ready_in = 1'b1;
    eth_busy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      b = 16'h1000 + 16'(4 * p * 17);
      e = {b, b + 16'd17, b + 16'd34, b + 16'd51};
      recv_packet("b2b", 32'(4 * p), e, 0, 10, 1'b1, w);
      if (p > 0) begin
        n_chk++;
        if (w !== 1) $display("FAIL b2b_gap: got %0d idle cycles expected 1", w);
        else n_pass++;
      end
    end
    ready_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_busy_holdoff();
    test_timeout_retry();
    test_overflow();
    test_reset_mid_stream();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
